// File: rtl/marker_tracker_if.sv
// rtl/marker_tracker_if.sv - pixel input and marker result bundle for marker_tracker
interface marker_tracker_if;
  logic        i_sof;
  logic        i_pix_valid;
  logic [10:0] i_x;
  logic [10:0] i_y;
  logic [7:0]  i_rgb [3];
  logic [10:0] o_left [2];
  logic [10:0] o_right [2];
  logic [10:0] o_up [2];
  logic [10:0] o_down [2];
  logic [19:0] o_hit_cnt;
  logic        o_predict_valid;
  logic        o_frame_end;

  modport master (
    output i_sof, i_pix_valid, i_x, i_y, i_rgb,
    input  o_left, o_right, o_up, o_down, o_hit_cnt, o_predict_valid, o_frame_end
  );

  modport slave (
    input  i_sof, i_pix_valid, i_x, i_y, i_rgb,
    output o_left, o_right, o_up, o_down, o_hit_cnt, o_predict_valid, o_frame_end
  );
endinterface

// File: rtl/marker_tracker.sv
// rtl/marker_tracker.sv - red-marker extreme-point tracker; MARKER_SMOOTH_EN averages consecutive valid publishes
// Point slots: 0/1 left x/y, 2/3 right x/y, 4/5 up x/y, 6/7 down x/y.
module marker_tracker #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [7:0]  R_MIN      = 8'd160,
  parameter logic [7:0]  G_MAX      = 8'd90,
  parameter logic [7:0]  B_MAX      = 8'd90,
  parameter logic [19:0] MIN_PIXELS = 20'd16
) (
  input logic              i_clk,
  input logic              i_rst,
  marker_tracker_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUBLISH} state_t;

  localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] SENTINEL = 11'd2023;

  state_t      state_q, state_d;
  logic [10:0] acc_q [8];
  logic [10:0] acc_d [8];
  logic [10:0] base [8];
  logic [10:0] pub_q [8];
  logic [10:0] pub_d [8];
  logic [19:0] cnt_q, cnt_d, base_cnt;
  logic [19:0] hit_q, hit_d;
  logic        pulse_q, pulse_d;
  logic        pix_ok, match, start, accum, last_pix, det_ok;
`ifdef MARKER_SMOOTH_EN
  logic        hist_q, hist_d;

  function automatic logic [10:0] avg2(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11:1];
  endfunction
`endif

  always_comb begin
    pix_ok   = bus.i_pix_valid && (bus.i_x <= X_LAST) && (bus.i_y <= Y_LAST);
    match    = pix_ok && (bus.i_rgb[0] >= R_MIN) && (bus.i_rgb[1] < G_MAX) && (bus.i_rgb[2] < B_MAX);
    start    = pix_ok && bus.i_sof && (state_q != S_PUBLISH);
    accum    = start || (pix_ok && (state_q == S_SCAN));
    last_pix = pix_ok && !bus.i_sof && (bus.i_x == X_LAST) && (bus.i_y == Y_LAST);
  end

  // A sof pixel restarts the accumulators and is then folded in like any other pixel.
  always_comb begin
    base     = acc_q;
    base_cnt = cnt_q;
    if (start) begin
      base[0]  = 11'd2047; base[1] = 11'd0;
      base[2]  = 11'd0;    base[3] = 11'd0;
      base[4]  = 11'd0;    base[5] = 11'd2047;
      base[6]  = 11'd0;    base[7] = 11'd0;
      base_cnt = 20'd0;
    end
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accum) begin
      acc_d = base;
      cnt_d = base_cnt;
      if (match) begin
        if (base_cnt != 20'hFFFFF) cnt_d = base_cnt + 20'd1;
        if (bus.i_x < base[0]) begin acc_d[0] = bus.i_x; acc_d[1] = bus.i_y; end
        if (bus.i_x > base[2]) begin acc_d[2] = bus.i_x; acc_d[3] = bus.i_y; end
        if (bus.i_y < base[5]) begin acc_d[4] = bus.i_x; acc_d[5] = bus.i_y; end
        if (bus.i_y > base[7]) begin acc_d[6] = bus.i_x; acc_d[7] = bus.i_y; end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SCAN;
      S_SCAN:    if (last_pix) state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    det_ok  = (cnt_q >= MIN_PIXELS);
    pub_d   = pub_q;
    hit_d   = hit_q;
    pulse_d = (state_q == S_PUBLISH);
`ifdef MARKER_SMOOTH_EN
    hist_d  = hist_q;
`endif
    if (state_q == S_PUBLISH) begin
      hit_d = cnt_q;
      for (int i = 0; i < 8; i++) begin
        pub_d[i] = det_ok ? acc_q[i] : SENTINEL;
`ifdef MARKER_SMOOTH_EN
        if (det_ok && hist_q) pub_d[i] = avg2(pub_q[i], acc_q[i]);
`endif
      end
`ifdef MARKER_SMOOTH_EN
      hist_d = det_ok;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 20'd0;
      hit_q   <= 20'd0;
      pulse_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= 11'd0;
        pub_q[i] <= SENTINEL;
      end
`ifdef MARKER_SMOOTH_EN
      hist_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      pulse_q <= pulse_d;
      acc_q   <= acc_d;
      pub_q   <= pub_d;
`ifdef MARKER_SMOOTH_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign bus.o_left[0]      = pub_q[0];
  assign bus.o_left[1]      = pub_q[1];
  assign bus.o_right[0]     = pub_q[2];
  assign bus.o_right[1]     = pub_q[3];
  assign bus.o_up[0]        = pub_q[4];
  assign bus.o_up[1]        = pub_q[5];
  assign bus.o_down[0]      = pub_q[6];
  assign bus.o_down[1]      = pub_q[7];
  assign bus.o_hit_cnt      = hit_q;
  assign bus.o_predict_valid = pulse_q;
  assign bus.o_frame_end    = pulse_q;

endmodule

// File: tb/tb_marker_tracker.sv
// tb/tb_marker_tracker.sv - directed and randomized frames checked against a pixel-list model
module tb_marker_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_seen = 0;
  int   pub_exp = 0;

  int   mq_x[$];
  int   mq_y[$];
  bit   m_in = 0;
  int   e_pt[8];
  int   e_cnt;
  int   m_prev[8];
  bit   m_prev_v = 0;

  marker_tracker_if bus ();
  marker_tracker dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_predict_valid === 1'b1) pulse_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sof, input bit v, input int x, input int y,
                       input int r, input int g, input int b);
    bus.i_sof = sof; bus.i_pix_valid = v;
    bus.i_x = 11'(x); bus.i_y = 11'(y);
    bus.i_rgb[0] = 8'(r); bus.i_rgb[1] = 8'(g); bus.i_rgb[2] = 8'(b);
  endtask

  task automatic send(input bit sof, input bit v, input int x, input int y,
                      input int r, input int g, input int b);
    @(negedge clk);
    drive(sof, v, x, y, r, g, b);
    if (v && x < 640 && y < 480) begin
      if (sof) begin mq_x.delete(); mq_y.delete(); m_in = 1; end
      if (m_in) begin
        if (r >= 160 && g < 90 && b < 90) begin mq_x.push_back(x); mq_y.push_back(y); end
        if (!sof && x == 639 && y == 479) m_in = 0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_publish();
    int n, il, ir, iu, id;
    n = mq_x.size();
    e_cnt = n;
    if (n >= 16) begin
      il = 0; ir = 0; iu = 0; id = 0;
      for (int i = 1; i < n; i++) begin
        if (mq_x[i] < mq_x[il]) il = i;
        if (mq_x[i] > mq_x[ir]) ir = i;
        if (mq_y[i] < mq_y[iu]) iu = i;
        if (mq_y[i] > mq_y[id]) id = i;
      end
      e_pt[0] = mq_x[il]; e_pt[1] = mq_y[il];
      e_pt[4] = mq_x[iu]; e_pt[5] = mq_y[iu];
      // right/down start from (0,0) and need a strictly larger value to move
      if (mq_x[ir] == 0) begin e_pt[2] = 0; e_pt[3] = 0; end
      else begin e_pt[2] = mq_x[ir]; e_pt[3] = mq_y[ir]; end
      if (mq_y[id] == 0) begin e_pt[6] = 0; e_pt[7] = 0; end
      else begin e_pt[6] = mq_x[id]; e_pt[7] = mq_y[id]; end
    end else begin
      for (int i = 0; i < 8; i++) e_pt[i] = 2023;
    end
`ifdef MARKER_SMOOTH_EN
    if (n >= 16 && m_prev_v) for (int i = 0; i < 8; i++) e_pt[i] = (m_prev[i] + e_pt[i]) / 2;
    m_prev = e_pt;
    m_prev_v = (n >= 16);
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [10:0] obs[8];
    obs[0] = bus.o_left[0];  obs[1] = bus.o_left[1];
    obs[2] = bus.o_right[0]; obs[3] = bus.o_right[1];
    obs[4] = bus.o_up[0];    obs[5] = bus.o_up[1];
    obs[6] = bus.o_down[0];  obs[7] = bus.o_down[1];
    for (int i = 0; i < 8; i++) chk($sformatf("%s_pt%0d", tag, i), 32'(obs[i]), 32'(e_pt[i]));
    chk({tag, "_hit_cnt"}, 32'(bus.o_hit_cnt), 32'(e_cnt));
  endtask

  task automatic check_publish(input string tag, input bit drop_pix);
    model_publish();
    @(negedge clk);
    if (drop_pix) drive(1, 1, 5, 5, 220, 10, 10);
    else drive(0, 0, 0, 0, 0, 0, 0);
    chk({tag, "_early_pulse"}, 32'(bus.o_predict_valid), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk({tag, "_predict_valid"}, 32'(bus.o_predict_valid), 32'd1);
    chk({tag, "_frame_end"}, 32'(bus.o_frame_end), 32'd1);
    check_outputs(tag);
    pub_exp++;
    @(negedge clk);
    chk({tag, "_pulse_width"}, 32'(bus.o_predict_valid), 32'd0);
  endtask

  task automatic blob(input int x0, input int y0);
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 5; xx++) send(0, 1, x0 + xx, y0 + yy, 200, 30, 30);
  endtask

  task automatic rand_xy(output int x, output int y, input int xmax, input int ymax);
    x = $urandom_range(0, xmax);
    y = $urandom_range(0, ymax);
    if (x == 639 && y == 479) x = 638;
  endtask

  task automatic rand_dark(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      rand_xy(x, y, 700, 520);
      send(0, $urandom_range(0, 3) != 0, x, y, $urandom_range(0, 159), $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  task automatic rand_pixels(input int n);
    int x, y, r, g, b, k;
    for (int i = 0; i < n; i++) begin
      rand_xy(x, y, 680, 500);
      k = $urandom_range(0, 2);
      if (k == 0) begin r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255); end
      else if (k == 1) begin r = $urandom_range(155, 165); g = $urandom_range(85, 95); b = $urandom_range(85, 95); end
      else begin r = 230; g = 20; b = 20; end
      send(0, $urandom_range(0, 7) != 0, x, y, r, g, b);
    end
  endtask

  task automatic empty_frame(input string tag);
    send(1, 1, 0, 0, 0, 0, 0);
    rand_dark(6);
    send(0, 1, 639, 479, 0, 0, 0);
    check_publish(tag, 0);
  endtask

  initial begin
    int x, y;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) e_pt[i] = 2023;
    e_cnt = 0;
    check_outputs("reset");
    chk("reset_predict_valid", 32'(bus.o_predict_valid), 32'd0);
    chk("reset_frame_end", 32'(bus.o_frame_end), 32'd0);

    send(1, 1, 0, 0, 0, 0, 0);
    rand_dark(20);
    blob(100, 200);
    rand_dark(20);
    send(0, 1, 639, 479, 0, 0, 0);
    check_publish("blob", 0);
    chk("blob_left_x", 32'(bus.o_left[0]), 32'd100);
    chk("blob_right", 32'({bus.o_right[0], bus.o_right[1]}), 32'({11'd104, 11'd200}));
    chk("blob_down", 32'({bus.o_down[0], bus.o_down[1]}), 32'({11'd100, 11'd204}));
    chk("blob_cnt", 32'(bus.o_hit_cnt), 32'd25);

    send(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin rand_xy(x, y, 639, 479); send(0, 1, x, y, 250, 0, 0); end
    send(0, 1, 639, 479, 0, 0, 0);
    check_publish("below_thr", 1);
    chk("below_thr_left_x", 32'(bus.o_left[0]), 32'd2023);
    chk("below_thr_cnt", 32'(bus.o_hit_cnt), 32'd15);

    for (int i = 0; i < 5; i++) send(0, 1, 10 + i, 10, 250, 0, 0);
    repeat (3) idle();
    chk("idle_no_pulse", 32'(pulse_seen), 32'(pub_exp));

    send(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(0, 1, 30 + i, 40, 160, 89, 89);
    send(0, 1, 10, 41, 159, 0, 0);
    send(0, 1, 11, 41, 255, 90, 0);
    send(0, 1, 12, 41, 255, 0, 90);
    send(0, 1, 639, 479, 0, 0, 0);
    check_publish("colour", 0);
    chk("colour_cnt", 32'(bus.o_hit_cnt), 32'd16);

    send(1, 1, 0, 0, 0, 0, 0);
    blob(50, 50);
    send(1, 1, 300, 100, 0, 0, 0);
    blob(20, 300);
    rand_dark(10);
    chk("abort_no_pulse", 32'(pulse_seen), 32'(pub_exp));
    send(0, 1, 639, 479, 0, 0, 0);
    check_publish("abort", 0);
    chk("abort_cnt", 32'(bus.o_hit_cnt), 32'd25);

    for (int f = 0; f < 6; f++) begin
      send(1, 1, $urandom_range(0, 639), $urandom_range(0, 478), 240, 10, 10);
      rand_pixels($urandom_range(10, 70));
      send(0, 1, 639, 479, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      check_publish($sformatf("rand%0d", f), f[0]);
    end

`ifdef MARKER_SMOOTH_EN
    empty_frame("sm_clear");
    send(1, 1, 0, 0, 0, 0, 0); blob(100, 200); send(0, 1, 639, 479, 0, 0, 0);
    check_publish("sm_f1", 0);
    chk("sm_f1_left_x", 32'(bus.o_left[0]), 32'd100);
    send(1, 1, 0, 0, 0, 0, 0); blob(110, 200); send(0, 1, 639, 479, 0, 0, 0);
    check_publish("sm_f2", 0);
    chk("sm_f2_left_x", 32'(bus.o_left[0]), 32'd105);
    empty_frame("sm_f3");
    chk("sm_f3_left_x", 32'(bus.o_left[0]), 32'd2023);
`else
    empty_frame("empty");
`endif

    send(1, 1, 0, 0, 0, 0, 0);
    blob(200, 100);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    mq_x.delete(); mq_y.delete(); m_in = 0; m_prev_v = 0;
    for (int i = 0; i < 8; i++) e_pt[i] = 2023;
    e_cnt = 0;
    check_outputs("midreset");
    send(0, 1, 639, 479, 250, 0, 0);
    repeat (4) idle();
    chk("midreset_no_pulse", 32'(pulse_seen), 32'(pub_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/marker_tracker.md
# marker_tracker

Pixel-stream marker detector that sits directly upstream of the game-logic stage. It scans every active camera pixel and keeps the four extreme points (leftmost, rightmost, topmost, bottommost) of the pixels that pass a red-marker colour test. At frame end it publishes those points with a one-cycle `o_predict_valid` pulse, or the not-found sentinel 2023 if too few pixels matched. Game logic derives the player's hit position from these outputs.

## Interface

- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.
- `R_MIN`, default 8'd160: a match needs R ≥ R_MIN.
- `G_MAX`, default 8'd90: a match needs G < G_MAX.
- `B_MAX`, default 8'd90: a match needs B < B_MAX.
- `MIN_PIXELS`, default 20'd16: minimum matched-pixel count for a valid detection.
- `i_clk`, input, 1: single clock; all state updates on the rising edge.
- `i_rst`, input, 1: reset. Asynchronous and active-high.
- `i_sof`, input, 1: start-of-frame strobe. Qualifies the same-cycle pixel as the first of a new frame.
- `i_pix_valid`, input, 1: `i_x`, `i_y` and `i_rgb` carry an active pixel this cycle.
- `i_x`, input, 11: pixel column, 0..H_ACTIVE-1.
- `i_y`, input, 11: pixel row, 0..V_ACTIVE-1.
- `i_rgb`, input, [7:0] ×3 unpacked: [0]=R, [1]=G, [2]=B.
- `o_left`, output, [10:0] ×2 unpacked: leftmost matched point, [0]=x, [1]=y. Same layout for the three outputs below.
- `o_right`, output, [10:0] ×2: rightmost matched point.
- `o_up`, output, [10:0] ×2: topmost matched point.
- `o_down`, output, [10:0] ×2: bottommost matched point.
- `o_hit_cnt`, output, 20: matched-pixel count of the last published frame.
- `o_predict_valid`, output, 1: one-cycle pulse; the point outputs are updated this cycle.
- `o_frame_end`, output, 1: one-cycle pulse coincident with `o_predict_valid`. Drives game-logic `ThisFrameEnd`.

## Operation

- **States:** S_IDLE, S_SCAN, S_PUBLISH. Reset enters S_IDLE.
- **S_IDLE:**
  - Pixels are ignored until `i_sof && i_pix_valid`.
  - On that event the accumulators are initialised, the same-cycle pixel is included, and the block moves to S_SCAN.
- **Accumulator initial values:**
  - left.x = 2047, up.y = 2047.
  - right.x = 0, down.y = 0.
  - cnt = 0.
  - The companion coordinate of each extreme point is 0.
- **Match test:** `i_pix_valid && R >= R_MIN && G < G_MAX && B < B_MAX`.
- **Updates on a match:**
  - cnt increments, saturating at 20'hFFFFF.
  - left is replaced if x < left.x; right if x > right.x; up if y < up.y; down if y > down.y.
  - All comparisons are strict, so on ties the first pixel in raster order wins.
- **S_SCAN, `i_sof` seen again:** the frame is aborted with no publish. Accumulators re-initialise with the sof pixel and the block stays in S_SCAN.
- **S_SCAN, end of frame:** accepting the pixel at (H_ACTIVE-1, V_ACTIVE-1) moves the block to S_PUBLISH. If `i_sof` is also asserted that cycle, sof takes priority.
- **S_PUBLISH (one cycle):**
  - If cnt ≥ MIN_PIXELS, the four points are registered to the outputs.
  - Otherwise all eight coordinates become 11'd2023.
  - `o_hit_cnt` takes cnt in both cases.
  - Pulses assert, then the block returns to S_IDLE.
  - A pixel arriving during S_PUBLISH is dropped, including one with `i_sof` set.
- Outputs hold between publishes.
- Pixels outside the active range, or with `i_pix_valid` low, never update any state.

## Timing

- **Reset values:**
  - All eight coordinates are 11'd2023.
  - `o_hit_cnt` = 0, `o_predict_valid` = 0, `o_frame_end` = 0.
- Reset asserted mid-frame discards the frame. No pulse is produced.
- **Latency:**
  - The last pixel is sampled at edge k, giving state S_PUBLISH.
  - At edge k+1 the outputs update and both pulses go high for exactly one cycle, k+1 to k+2.
- There is no back-pressure. The upstream pixel stream is free-running.

## Configuration

- **`MARKER_SMOOTH_EN` defined:**
  - When the previous publish and the current publish are both valid detections, each published coordinate is (prev + new) >> 1, computed in 12 bits.
  - An invalid frame publishes the sentinel and clears the history, so the next valid frame is published raw.
  - Latency is unchanged.
- **`MARKER_SMOOTH_EN` undefined:** raw extremes are published, and no history registers are built.

## Test plan

- **Reset:** hold `i_rst` 3 cycles, then release → all coordinates 2023, pulses 0, `o_hit_cnt` 0.
- **Single blob:** one full frame with a red 5×5 block at x 100..104, y 200..204, all else black → one pulse two edges after pixel (639,479):
  - left = (100,200), right = (104,200), up = (100,200), down = (100,204).
  - `o_hit_cnt` = 25.
- **Below threshold:** frame with 15 matching pixels → coordinates 2023, `o_hit_cnt` = 15, pulse asserted.
- **Colour boundary:** pixel with R=159 → not counted. Pixel with R=160, G=89, B=89 → counted. Pixel with G=90 → not counted.
- **Frame abort:** `i_sof` reasserted at (300,100) mid-frame → no pulse, earlier matches discarded. Only the new frame is published.
- **Smoothing (macro on):** blob left.x 100 in frame 1, then left.x 110 in frame 2 → published left.x 100, then 105. A third empty frame → 2023.
